// File: rtl/ram_sync_bw.sv
// Byte-writable synchronous 16-bit RAM with power-on zero fill; RAM_PARITY_EN adds per-lane even parity.
// Latency: ACK, DO, ODD_ERR and PERR are registered one cycle after the accepting edge.
// Backpressure: BUSY holds off requests while the fill runs; otherwise one request is taken every cycle.
module ram_sync_bw #(
    parameter int AW         = 16,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW-1:0] A,
    input  logic [15:0]   DI,
    input  logic          REQ,
    input  logic          WE,
    input  logic          BYTE_OP,
`ifdef RAM_PARITY_EN
    input  logic          PINV,
`endif
    output logic [15:0]   DO,
    output logic          ACK,
    output logic          BUSY,
    output logic          ODD_ERR,
    output logic          PERR
);

    localparam int WAW   = AW - 1;
    localparam int DEPTH = 1 << WAW;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t         state;
    logic [WAW-1:0] cnt;

    logic [7:0] mem_hi [DEPTH];
    logic [7:0] mem_lo [DEPTH];

    logic [WAW-1:0] widx;
    logic           lane;
    logic           accept;
    logic [7:0]     rd_hi;
    logic [7:0]     rd_lo;
    logic           perr_now;

    logic           wen_hi;
    logic           wen_lo;
    logic [WAW-1:0] waddr;
    logic [7:0]     wd_hi;
    logic [7:0]     wd_lo;

    assign widx   = A[AW-1:1];
    assign lane   = A[0];
    assign accept = REQ && (state == S_RUN) && !RESET;
    assign rd_hi  = mem_hi[widx];
    assign rd_lo  = mem_lo[widx];

    // Single write port shared by the fill sequencer and user writes.
    always_comb begin
        wen_hi = 1'b0;
        wen_lo = 1'b0;
        waddr  = widx;
        wd_hi  = DI[15:8];
        wd_lo  = DI[7:0];
        if (!RESET) begin
            if (state == S_CLEAR) begin
                wen_hi = 1'b1;
                wen_lo = 1'b1;
                waddr  = cnt;
                wd_hi  = 8'h00;
                wd_lo  = 8'h00;
            end else if (accept && WE) begin
                if (BYTE_OP) begin
                    wd_hi  = DI[7:0];
                    wen_hi = lane;
                    wen_lo = !lane;
                end else if (!lane) begin
                    wen_hi = 1'b1;
                    wen_lo = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wen_hi) mem_hi[waddr] <= wd_hi;
        if (wen_lo) mem_lo[waddr] <= wd_lo;
    end

`ifdef RAM_PARITY_EN
    logic par_hi [DEPTH];
    logic par_lo [DEPTH];
    logic pinv_eff;
    logic bad_hi;
    logic bad_lo;

    // The fill always stores correct parity; injection applies only to user writes.
    assign pinv_eff = (state == S_RUN) && PINV;
    assign bad_hi   = (^rd_hi) ^ par_hi[widx];
    assign bad_lo   = (^rd_lo) ^ par_lo[widx];
    assign perr_now = BYTE_OP ? (lane ? bad_hi : bad_lo) : (bad_hi | bad_lo);

    always_ff @(posedge CLK) begin
        if (wen_hi) par_hi[waddr] <= (^wd_hi) ^ pinv_eff;
        if (wen_lo) par_lo[waddr] <= (^wd_lo) ^ pinv_eff;
    end
`else
    assign perr_now = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= INIT_CLEAR ? S_CLEAR : S_RUN;
            BUSY    <= INIT_CLEAR;
            cnt     <= '0;
            ACK     <= 1'b0;
            DO      <= 16'h0000;
            ODD_ERR <= 1'b0;
            PERR    <= 1'b0;
        end else begin
            ACK     <= accept;
            ODD_ERR <= 1'b0;
            PERR    <= 1'b0;
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == WAW'(DEPTH - 1)) begin
                        state <= S_RUN;
                        BUSY  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (!BYTE_OP && lane) begin
                            DO      <= 16'h0000;
                            ODD_ERR <= 1'b1;
                        end else if (!WE) begin
                            DO   <= BYTE_OP ? {8'h00, (lane ? rd_hi : rd_lo)} : {rd_hi, rd_lo};
                            PERR <= perr_now;
                        end
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: doc/ram_sync_bw.md
RAM_SYNC_BW -- requirements
Module: ram_sync_bw

Interface
REQ-001 Parameter AW, default 16: byte-address width; depth SHALL be 2^(AW-1) 16-bit words.
REQ-002 Parameter INIT_CLEAR, default 1: 1 = zero-fill memory after reset; 0 = no fill.
REQ-003 CLK  in  1  single clock; all state SHALL change on rising edge only.
REQ-004 RESET  in  1  reset, synchronous and active-high.
REQ-005 A  in  AW  byte address; word index A[AW-1:1], lane select A[0].
REQ-006 DI  in  16  write data.
REQ-007 REQ  in  1  access request, sampled on a rising edge while BUSY=0.
REQ-008 WE  in  1  1 = write, 0 = read; qualified by REQ.
REQ-009 BYTE_OP  in  1  1 = byte access, 0 = word access.
REQ-010 DO  out  16  registered read data.
REQ-011 ACK  out  1  one-cycle completion pulse per accepted request.
REQ-012 BUSY  out  1  high while the clear sequence runs; requests SHALL NOT be accepted.
REQ-013 ODD_ERR  out  1  pulses with ACK for a word access at an odd address.
REQ-014 PERR  out  1  parity error, pulses with ACK (see Configuration).
REQ-015 PINV  in  1  inverts stored parity on write (error injection); present only with the macro.

Function
REQ-016 States SHALL be CLEAR and RUN; reset SHALL enter CLEAR if INIT_CLEAR=1, else RUN.
REQ-017 In CLEAR: a counter from 0 SHALL write 16'o0 (plus correct parity) to one word per cycle; after writing word 2^(AW-1)-1, the next cycle SHALL be RUN with BUSY=0.
REQ-018 Accept condition: REQ=1 and state RUN at a rising edge; one request SHALL be accepted per cycle, back-to-back allowed.
REQ-019 ACK SHALL assert exactly one cycle after acceptance; with back-to-back requests, ACK SHALL remain high continuously.
REQ-020 Word write, A[0]=0: both lanes SHALL be written at the accept edge, high lane = DI[15:8], low lane = DI[7:0].
REQ-021 Byte write: DI[7:0] SHALL be written to the high lane if A[0]=1, else the low lane; the other lane SHALL be unchanged.
REQ-022 Word read: DO SHALL be {high, low}, valid in the ACK cycle.
REQ-023 Byte read: DO SHALL be {8'b0, selected lane}.
REQ-024 Read-after-write to the same address in consecutive cycles SHALL return the new data.
REQ-025 A word access with A[0]=1 SHALL NOT write memory; DO SHALL be 0 and ODD_ERR SHALL be 1 in its ACK cycle.
REQ-026 DO SHALL hold its value between read ACKs; write ACKs SHALL NOT change DO.
REQ-027 ODD_ERR and PERR SHALL be 0 in every cycle where ACK=0.

Reset
REQ-028 RESET SHALL force ACK=0, DO=0, ODD_ERR=0, PERR=0, clear counter=0, and BUSY=INIT_CLEAR in the following cycle.
REQ-029 RESET during CLEAR SHALL restart the fill at word 0.
REQ-030 RESET during RUN SHALL drop any pending ACK; no write SHALL occur on an edge where RESET=1.
REQ-031 Memory contents SHALL NOT be reset except by the CLEAR sequence.

Configuration
REQ-032 With RAM_PARITY_EN defined:
  - each lane SHALL store an even-parity bit, XORed with PINV on write;
  - every read SHALL check the accessed lane(s), and PERR SHALL pulse with ACK on mismatch.
REQ-033 Without RAM_PARITY_EN: no parity storage, PINV port absent, PERR tied 0.

Verification
REQ-034 AW=6, INIT_CLEAR=1: RESET for 1 cycle, then REQ held at 1 -> BUSY for exactly 32 cycles, no ACK during that time, then word read of 6'o10 -> DO=16'o0.
REQ-035 Word write 16'o123456 at 6'o4, then byte read at 6'o5 -> DO=16'o000247; byte write 8'o377 at 6'o4 then word read -> DO=16'o123777.
REQ-036 Back-to-back: write 16'o1 at 6'o2, read 6'o2, read 6'o0 on consecutive cycles -> ACK high for 3 cycles, DO=16'o1 then 16'o0.
REQ-037 Word write 16'o7 at 6'o3 -> ODD_ERR=1 with ACK; word read at 6'o2 -> DO unchanged from the prior contents.
REQ-038 RESET asserted at clear count 10 -> BUSY remains high for a full 32 cycles after release.
REQ-039 RAM_PARITY_EN: byte write with PINV=1 at 6'o1, then byte read at 6'o1 -> PERR=1; word read at 6'o0 -> PERR=1; rewrite with PINV=0 -> PERR=0.
